// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multi-cycle control sequencer for the MIPS-lite datapath. Decodes the opcode
//   held in the instruction register and steps the shared ALU and memory through
//   FETCH..WB. Waits on the memory-ready handshake. Halts on an illegal opcode.
//   Counts retired instructions.
//
// Parameters
//   CNT_W          width of the retired-instruction counter
//
// Ports
//   clk            system clock; all state updates happen on posedge
//   reset          synchronous, active-high; overrides every other input
//   run            leave IDLE and begin fetching (sampled only in IDLE)
//   opcode         instruc[31:26] from the instruction register
//   mem_ready      the memory access completes this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if the ALU zero flag is set (beq)
//   iord           memory address select: 0 = pc, 1 = alu_out
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       latch the instruction register
//   reg_dst        register write select: 0 = rt, 1 = rd
//   mem_to_reg     write-back source: 0 = alu_out, 1 = memory data register
//   reg_write      register file write enable
//   alu_src_a      ALU operand A: 0 = pc, 1 = readdata1
//   alu_src_b      ALU operand B: 0 = readdata2, 1 = 4, 2 = extad, 3 = extad<<2
//   ori_sel        use zextad instead of extad when alu_src_b = 2
//   alu_op         00 add, 01 sub, 10 funct-decoded, 11 or
//   pc_source      0 = ALU result, 1 = alu_out register, 2 = jump address
//   state          current state encoding (debug)
//   halted         the sequencer is in HALT
//   instr_count    retired instruction count; wraps to zero

module mc_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ori_sel,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StRwb    = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StOriEx  = 4'd11,
    StOriWb  = 4'd12,
    StHalt   = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpOri   = 6'b001101;

  // Moore control bundle. pc_write/ir_write in FETCH depend on mem_ready and
  // are combined outside the register.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ori_sel;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  state_e           state_q, state_d;
  ctl_t             ctl_q;
  logic             fetch_q;
  logic             halted_q;
  logic [CNT_W-1:0] instr_count_q;
  logic             retire;
  logic             fetch_done;

  // Per-state control decode. Anything not set here stays 0.
  function automatic ctl_t decode_ctl(input state_e st);
    ctl_t c;
    c = '0;
    unique case (st)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'd1;
      end
      StDecode: begin
        // Branch target precompute: pc + (extad << 2).
        c.alu_src_b = 2'd3;
      end
      StMemAdr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      StMemRd: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      StExec: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      StRwb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'd1;
      end
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'd2;
      end
      StOriEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.ori_sel   = 1'b1;
        c.alu_op    = 2'b11;
      end
      StOriWb: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state and retire decode.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        unique case (opcode)
          OpRtype:    state_d = StExec;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpOri:      state_d = StOriEx;
          default:    state_d = StHalt;
        endcase
      end
      StMemAdr: begin
        state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec:   state_d = StRwb;
      StRwb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StOriEx:  state_d = StOriWb;
      StOriWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      ctl_q         <= '0;
      fetch_q       <= 1'b0;
      halted_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q  <= state_d;
      ctl_q    <= decode_ctl(state_d);
      fetch_q  <= (state_d == StFetch);
      halted_q <= (state_d == StHalt);
      if (retire) instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

  // The fetch handshake is the only input-dependent enable; reset suppresses it
  // so no PC/IR update escapes in the reset cycle.
  assign fetch_done = fetch_q & mem_ready & ~reset;

  assign pc_write      = ctl_q.pc_write | fetch_done;
  assign ir_write      = fetch_done;
  assign pc_write_cond = ctl_q.pc_write_cond;
  assign iord          = ctl_q.iord;
  assign mem_read      = ctl_q.mem_read;
  assign mem_write     = ctl_q.mem_write;
  assign reg_dst       = ctl_q.reg_dst;
  assign mem_to_reg    = ctl_q.mem_to_reg;
  assign reg_write     = ctl_q.reg_write;
  assign alu_src_a     = ctl_q.alu_src_a;
  assign alu_src_b     = ctl_q.alu_src_b;
  assign ori_sel       = ctl_q.ori_sel;
  assign alu_op        = ctl_q.alu_op;
  assign pc_source     = ctl_q.pc_source;
  assign state         = state_q;
  assign halted        = halted_q;
  assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm. The stimulus process drives one cycle
// at a time and queues the expected outputs for that cycle; the monitor pops
// and compares on the falling edge. The counter is narrowed so the wrap case
// fits in a short run.

module tb_mc_control_fsm;

  localparam int CW = 4;

  localparam logic [3:0] SIdle = 4'd0,  SFetch  = 4'd1,  SDecode = 4'd2,  SMemAdr = 4'd3;
  localparam logic [3:0] SMemRd = 4'd4, SMemWb  = 4'd5,  SMemWr  = 4'd6,  SExec   = 4'd7;
  localparam logic [3:0] SRwb = 4'd8,   SBranch = 4'd9,  SJump   = 4'd10, SOriEx  = 4'd11;
  localparam logic [3:0] SOriWb = 4'd12, SHalt  = 4'd15;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpJ = 6'b000010, OpOri = 6'b001101;
  localparam logic [5:0] OpBad = 6'b111111;

  typedef struct packed {
    logic       pcw;
    logic       pcc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic       ori;
    logic [1:0] aop;
    logic [1:0] psrc;
  } ctl_t;

  typedef struct {
    int            cyc;
    logic [3:0]    st;
    ctl_t          c;
    logic          h;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, run, mem_ready;
  logic [5:0]    opcode;
  logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic          reg_dst, mem_to_reg, reg_write, alu_src_a, ori_sel;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic          halted;
  logic [CW-1:0] instr_count;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .ori_sel       (ori_sel),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .halted        (halted),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected controls per state, written from the state table.
  function automatic ctl_t model(input logic [3:0] st, input logic mr, input logic rst);
    ctl_t c;
    c = '0;
    case (st)
      SFetch:  begin c.mrd = 1; c.asb = 2'd1; c.irw = mr & ~rst; c.pcw = mr & ~rst; end
      SDecode: c.asb = 2'd3;
      SMemAdr: begin c.asa = 1; c.asb = 2'd2; end
      SMemRd:  begin c.mrd = 1; c.iord = 1; end
      SMemWb:  begin c.rw = 1; c.m2r = 1; end
      SMemWr:  begin c.mwr = 1; c.iord = 1; end
      SExec:   begin c.asa = 1; c.aop = 2'b10; end
      SRwb:    begin c.rw = 1; c.rdst = 1; end
      SBranch: begin c.asa = 1; c.aop = 2'b01; c.pcc = 1; c.psrc = 2'd1; end
      SJump:   begin c.pcw = 1; c.psrc = 2'd2; end
      SOriEx:  begin c.asa = 1; c.asb = 2'd2; c.ori = 1; c.aop = 2'b11; end
      SOriWb:  c.rw = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Drive this cycle's inputs, queue what the DUT must show during it, advance.
  task automatic tick(input logic rst, input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] est, input int ecnt);
    exp_t e;
    reset     = rst;
    run       = r;
    opcode    = op;
    mem_ready = mr;
    e.cyc = cyc;
    e.st  = est;
    e.c   = model(est, mr, rst);
    e.h   = (est == SHalt);
    e.cnt = ecnt[CW-1:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor.
  exp_t me;
  ctl_t got;
  always @(negedge clk) begin
    got = '{pcw: pc_write, pcc: pc_write_cond, iord: iord, mrd: mem_read, mwr: mem_write,
            irw: ir_write, rdst: reg_dst, m2r: mem_to_reg, rw: reg_write, asa: alu_src_a,
            asb: alu_src_b, ori: ori_sel, aop: alu_op, psrc: pc_source};
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      total++;
      if (me.cyc != cyc) begin
        bad++;
        $display("FAIL stale_entry cyc=%0d: entry for cyc %0d never checked", cyc, me.cyc);
      end else if (state !== me.st || got !== me.c || halted !== me.h ||
                   instr_count !== me.cnt) begin
        bad++;
        $display("FAIL cycle_%0d: got state=%0d ctl=%b halted=%b count=%0d, want state=%0d ctl=%b halted=%b count=%0d",
                 cyc, state, got, halted, instr_count, me.st, me.c, me.h, me.cnt);
      end
      // Mutual exclusion must hold in every checked cycle.
      total++;
      if ((mem_read === 1'b1 && mem_write === 1'b1) ||
          (mem_write === 1'b1 && reg_write === 1'b1)) begin
        bad++;
        $display("FAIL exclusive_cyc%0d: got mem_read=%b mem_write=%b reg_write=%b, want no overlap",
                 cyc, mem_read, mem_write, reg_write);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish within time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; opcode = OpR; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // Idle with run low.
    for (int i = 0; i < 5; i++) tick(0, 0, OpR, 0, SIdle, 0);

    // R-type: 1,2,7,8 then retire.
    tick(0, 1, OpR, 1, SIdle, 0);
    tick(0, 0, OpR, 1, SFetch, 0);
    tick(0, 0, OpR, 1, SDecode, 0);
    tick(0, 0, OpR, 1, SExec, 0);
    tick(0, 0, OpR, 1, SRwb, 0);

    // lw with a stalled fetch and 3 stall cycles in MEMRD.
    tick(0, 0, OpLw, 0, SFetch, 1);
    tick(0, 0, OpLw, 1, SFetch, 1);
    tick(0, 0, OpLw, 1, SDecode, 1);
    tick(0, 0, OpLw, 1, SMemAdr, 1);
    tick(0, 0, OpLw, 0, SMemRd, 1);
    tick(0, 0, OpLw, 0, SMemRd, 1);
    tick(0, 0, OpLw, 0, SMemRd, 1);
    tick(0, 0, OpLw, 1, SMemRd, 1);
    tick(0, 0, OpLw, 0, SMemWb, 1);

    // sw, beq, j, ori.
    tick(0, 0, OpSw, 1, SFetch, 2);
    tick(0, 0, OpSw, 1, SDecode, 2);
    tick(0, 0, OpSw, 1, SMemAdr, 2);
    tick(0, 0, OpSw, 0, SMemWr, 2);
    tick(0, 0, OpSw, 1, SMemWr, 2);
    tick(0, 0, OpBeq, 1, SFetch, 3);
    tick(0, 0, OpBeq, 1, SDecode, 3);
    tick(0, 0, OpBeq, 1, SBranch, 3);
    tick(0, 0, OpJ, 1, SFetch, 4);
    tick(0, 0, OpJ, 1, SDecode, 4);
    tick(0, 0, OpJ, 1, SJump, 4);
    tick(0, 0, OpOri, 1, SFetch, 5);
    tick(0, 0, OpOri, 1, SDecode, 5);
    tick(0, 0, OpOri, 1, SOriEx, 5);
    tick(0, 0, OpOri, 1, SOriWb, 5);

    // Illegal opcode halts; run toggling does not leave HALT; reset does.
    tick(0, 0, OpBad, 1, SFetch, 6);
    tick(0, 0, OpBad, 1, SDecode, 6);
    tick(0, 1, OpBad, 1, SHalt, 6);
    tick(0, 0, OpBad, 1, SHalt, 6);
    tick(0, 1, OpBad, 1, SHalt, 6);
    tick(1, 0, OpBad, 1, SHalt, 6);
    tick(0, 0, OpJ, 1, SIdle, 0);

    // Counter wrap: 2^CW jumps bring it back to zero.
    tick(0, 1, OpJ, 1, SIdle, 0);
    for (int i = 0; i < (1 << CW); i++) begin
      tick(0, 0, OpJ, 1, SFetch, i);
      tick(0, 0, OpJ, 1, SDecode, i);
      tick(0, 0, OpJ, 1, SJump, i);
    end

    // Reset while MEMWR waits: next cycle IDLE, nothing written, no retire.
    tick(0, 0, OpSw, 1, SFetch, 0);
    tick(0, 0, OpSw, 1, SDecode, 0);
    tick(0, 0, OpSw, 1, SMemAdr, 0);
    tick(1, 0, OpSw, 0, SMemWr, 0);
    tick(0, 0, OpSw, 1, SIdle, 0);
    tick(0, 0, OpSw, 1, SIdle, 0);

    @(negedge clk);
    #1;
    while (sb.size() != 0) begin
      me = sb.pop_front();
      total++;
      bad++;
      $display("FAIL drain: got unchecked entry for cyc %0d, want empty scoreboard", me.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
